// File: rtl/mem_arbiter_if.sv
// Bundle of the two cache request ports and the shared memory port of mem_arbiter.
// master = caches and memory model side, slave = the arbiter itself.
interface mem_arbiter_if #(
  parameter int ADDRESS_SIZE = 32,
  parameter int LINE_LENGTH  = 128
);
  logic                    i_request;
  logic [ADDRESS_SIZE-1:0] i_address;
  logic [LINE_LENGTH-1:0]  i_result;
  logic                    i_satisfied;

  logic                    d_request;
  logic [ADDRESS_SIZE-1:0] d_address;
  logic                    d_write;
  logic [LINE_LENGTH-1:0]  d_data;
  logic [LINE_LENGTH-1:0]  d_result;
  logic                    d_satisfied;

  logic                    mem_request;
  logic                    mem_write;
  logic [ADDRESS_SIZE-1:0] mem_address;
  logic [LINE_LENGTH-1:0]  mem_data;
  logic [LINE_LENGTH-1:0]  mem_result;
  logic                    mem_satisfied;

  modport master (
    output i_request, i_address, d_request, d_address, d_write, d_data,
    output mem_result, mem_satisfied,
    input  i_result, i_satisfied, d_result, d_satisfied,
    input  mem_request, mem_write, mem_address, mem_data
  );

  modport slave (
    input  i_request, i_address, d_request, d_address, d_write, d_data,
    input  mem_result, mem_satisfied,
    output i_result, i_satisfied, d_result, d_satisfied,
    output mem_request, mem_write, mem_address, mem_data
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one memory port between an instruction cache and a data cache, one transaction at a time.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin arbitration; default is fixed data-cache priority.
module mem_arbiter #(
  parameter int ADDRESS_SIZE = 32,
  parameter int LINE_LENGTH  = 128
) (
  input logic          clk,
  input logic          reset,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_t;

  state_t                  state_q, state_d;
  logic                    win_d_q;
  logic                    grant, capture, release_done, grant_d_sel, win_request;

  logic                    mem_request_q, mem_write_q;
  logic [ADDRESS_SIZE-1:0] mem_address_q;
  logic [LINE_LENGTH-1:0]  mem_data_q;
  logic [LINE_LENGTH-1:0]  i_result_q, d_result_q;
  logic                    i_satisfied_q, d_satisfied_q;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic last_d_q;  // last grant went to the data cache; reset value makes D win first
`endif

  assign win_request = win_d_q ? bus.d_request : bus.i_request;

  // NOTE: every signal written here gets a default first so no latch can be inferred.
  always_comb begin
    state_d      = state_q;
    grant        = 1'b0;
    capture      = 1'b0;
    release_done = 1'b0;
    grant_d_sel  = bus.d_request;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    if (bus.i_request && bus.d_request) grant_d_sel = !last_d_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.i_request || bus.d_request) begin
          grant   = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (bus.mem_satisfied) begin
          capture = 1'b1;
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        // Wait for both the winner and the memory to let go before re-arbitrating.
        if (!win_request && !bus.mem_satisfied) begin
          release_done = 1'b1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: result registers are plain flops, not memories, so they are reset to 0 like all outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      win_d_q       <= 1'b0;
      mem_request_q <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_address_q <= '0;
      mem_data_q    <= '0;
      i_result_q    <= '0;
      d_result_q    <= '0;
      i_satisfied_q <= 1'b0;
      d_satisfied_q <= 1'b0;
    end else begin
      if (grant) begin
        win_d_q       <= grant_d_sel;
        mem_request_q <= 1'b1;
        mem_write_q   <= grant_d_sel && bus.d_write;
        mem_address_q <= grant_d_sel ? bus.d_address : bus.i_address;
        mem_data_q    <= grant_d_sel ? bus.d_data : '0;
      end
      if (capture) begin
        mem_request_q <= 1'b0;
        if (win_d_q) begin
          d_satisfied_q <= 1'b1;
          if (!mem_write_q) d_result_q <= bus.mem_result;
        end else begin
          i_satisfied_q <= 1'b1;
          i_result_q    <= bus.mem_result;
        end
      end
      if (release_done) begin
        i_satisfied_q <= 1'b0;
        d_satisfied_q <= 1'b0;
      end
    end
  end

`ifdef MEM_ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     last_d_q <= 1'b0;
    else if (grant) last_d_q <= grant_d_sel;
  end
`endif

  assign bus.mem_request = mem_request_q;
  assign bus.mem_write   = mem_write_q;
  assign bus.mem_address = mem_address_q;
  assign bus.mem_data    = mem_data_q;
  assign bus.i_result    = i_result_q;
  assign bus.d_result    = d_result_q;
  assign bus.i_satisfied = i_satisfied_q;
  assign bus.d_satisfied = d_satisfied_q;

endmodule
